// File: rtl/note_event_fifo.sv
// note_event_fifo: times each held note in ticks and queues one event per
// completed note for the VGA panels (show-ahead FIFO, popped by rd_ack).
module note_event_fifo #(
   parameter int TICK_DIV = 10_000_000,
   parameter int DEPTH    = 16
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [7:0] key,
   input  logic [1:0] shift,
   input  logic       recording,
   input  logic       clear,
   input  logic       rd_ack,
   output logic       output_ready,
   output logic [9:0] data_out,
   output logic [9:0] duration,
   output logic       overflow
);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int AW = $clog2(DEPTH);
   localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);
   localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t        state, state_n;
   logic [TW-1:0] tcnt;
   logic          tick;
   logic [2:0]    idx;
   logic          cur_vld;
   logic [4:0]    cur, lat, lat_n;
   logic [4:0]    len, len_n;
   logic          push, pop, full, wr;
   logic [9:0]    push_data;
   logic [9:0]    mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   count;

   assign tick    = recording && (tcnt == TMAX);
   assign cur_vld = |key;
   assign cur     = {shift, idx};

   // Tick prescaler: runs only while recording, frozen otherwise.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)     tcnt <= '0;
      else if (clear)     tcnt <= '0;
      else if (recording) tcnt <= tick ? '0 : tcnt + 1'b1;
   end

   // Lowest set key bit wins on multi-key presses.
   always_comb begin
      idx = '0;
      for (int i = 7; i >= 0; i--)
         if (key[i]) idx = 3'(i);
   end

   // Note tracker: next state, latched note/length and event push.
   always_comb begin
      state_n   = state;
      lat_n     = lat;
      len_n     = len;
      push      = 1'b0;
      push_data = {lat, len};
      unique case (state)
         IDLE: begin
            if (recording && cur_vld) begin
               lat_n   = cur;
               len_n   = 5'd1;
               state_n = HOLD;
            end
         end
         HOLD: begin
            if (!recording) begin
               push    = 1'b1;
               state_n = IDLE;
            end else if (!cur_vld || cur != lat) begin
               push = 1'b1;
               if (cur_vld) begin
                  lat_n = cur;
                  len_n = 5'd1;
               end else begin
                  state_n = IDLE;
               end
            end else if (tick && len != 5'd31) begin
               len_n = len + 5'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Tracker state register; clear drops any held note.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= IDLE;
      else if (clear) state <= IDLE;
      else            state <= state_n;
   end

   // Latched note and its running length.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         lat <= '0;
         len <= '0;
      end else if (clear) begin
         lat <= '0;
         len <= '0;
      end else begin
         lat <= lat_n;
         len <= len_n;
      end
   end

   assign pop  = rd_ack && (count != '0);
   assign full = (count == FULL);
   assign wr   = push && (!full || pop);

   // Event storage; contents beyond count are don't-care.
   always_ff @(posedge sys_clk) begin
      if (wr && !clear) mem[wptr] <= push_data;
   end

   // FIFO pointers and occupancy; pointers wrap naturally.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (clear) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr)  wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         if (wr && !pop)      count <= count + 1'b1;
         else if (pop && !wr) count <= count - 1'b1;
      end
   end

   // Sticky drop flag.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)                 overflow <= 1'b0;
      else if (clear)                 overflow <= 1'b0;
      else if (push && full && !pop)  overflow <= 1'b1;
   end

   // Saturating recording-time counter.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)                         duration <= '0;
      else if (clear)                         duration <= '0;
      else if (tick && duration != 10'h3FF)   duration <= duration + 10'd1;
   end

   assign output_ready = (count != '0);
   assign data_out     = output_ready ? mem[rptr] : '0;

endmodule

// File: tb/tb_note_event_fifo.sv
// tb_note_event_fifo: random and directed stimulus, queue-based reference
// model feeding a scoreboard that a consumer/monitor process drains.
module tb_note_event_fifo;
   localparam int TICK_DIV = 4;
   localparam int DEPTH    = 16;

   logic       sys_clk   = 1'b0;
   logic       sys_rst_n = 1'b1;
   logic [7:0] key       = '0;
   logic [1:0] shift     = '0;
   logic       recording = 1'b0;
   logic       clear     = 1'b0;
   logic       rd_ack    = 1'b0;
   logic       output_ready;
   logic [9:0] data_out;
   logic [9:0] duration;
   logic       overflow;

   int n_chk  = 0;
   int n_pass = 0;
   bit cons_en   = 1'b0;
   bit force_ack = 1'b0;
   int pop_pct   = 50;

   int         tcnt  = 0;
   int         m_len = 0;
   int         m_dur = 0;
   bit         hold  = 1'b0;
   bit         m_ovf = 1'b0;
   logic [4:0] m_lat = '0;
   logic [9:0] exp_q [$];

   always #5 sys_clk = ~sys_clk;

   note_event_fifo #(
      .TICK_DIV(TICK_DIV),
      .DEPTH   (DEPTH)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .key         (key),
      .shift       (shift),
      .recording   (recording),
      .clear       (clear),
      .rd_ack      (rd_ack),
      .output_ready(output_ready),
      .data_out    (data_out),
      .duration    (duration),
      .overflow    (overflow)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t",
                    nm, act, act, exp, exp, $time);
   endtask

   function automatic logic [2:0] low_idx(input logic [7:0] k);
      for (int i = 0; i < 8; i++)
         if (k[i]) return 3'(i);
      return 3'd0;
   endfunction

   // Reference model: note timing rules expressed on integers and a queue.
   always @(posedge sys_clk or negedge sys_rst_n) begin : model
      bit         tk;
      bit         ev_go;
      bit         cv;
      logic [4:0] cn;
      logic [9:0] ev;
      if (!sys_rst_n || clear) begin
         tcnt  = 0;
         m_len = 0;
         m_dur = 0;
         hold  = 1'b0;
         m_ovf = 1'b0;
         m_lat = '0;
         exp_q.delete();
      end else begin
         tk = recording && (tcnt == TICK_DIV - 1);
         if (recording) tcnt = (tcnt + 1) % TICK_DIV;
         cv    = (key != 8'd0);
         cn    = {shift, low_idx(key)};
         ev_go = 1'b0;
         ev    = {m_lat, 5'(m_len)};
         if (hold) begin
            if (!recording || !cv || cn != m_lat) begin
               ev_go = 1'b1;
               hold  = 1'b0;
            end else if (tk && m_len < 31) begin
               m_len++;
            end
         end
         if (!hold && recording && cv) begin
            hold  = 1'b1;
            m_lat = cn;
            m_len = 1;
         end
         if (tk && m_dur < 1023) m_dur++;
         if (ev_go) begin
            if (exp_q.size() == DEPTH && !rd_ack) m_ovf = 1'b1;
            else exp_q.push_back(ev);
         end
      end
   end

   // Monitor/consumer: compares outputs, pops the scoreboard on each ack.
   always @(negedge sys_clk) begin : mon
      logic [9:0] exp_d;
      bit         want;
      exp_d = (exp_q.size() != 0) ? exp_q[0] : 10'd0;
      chk("ready", int'(output_ready), int'(exp_q.size() != 0));
      chk("data", int'(data_out), int'(exp_d));
      chk("duration", int'(duration), m_dur);
      chk("overflow", int'(overflow), int'(m_ovf));
      if (cons_en)
         want = (exp_q.size() != 0) &&
                (int'($urandom_range(0, 99)) < pop_pct);
      else
         want = force_ack;
      rd_ack = want;
      if (want && exp_q.size() != 0) void'(exp_q.pop_front());
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #2;
      end
   endtask

   task automatic pop1();
      force_ack = 1'b1;
      step(1);
      force_ack = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step(1);
      clear = 1'b0;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_ready"}, int'(output_ready), 0);
      chk({nm, "_data"}, int'(data_out), 0);
      chk({nm, "_dur"}, int'(duration), 0);
      chk({nm, "_ovf"}, int'(overflow), 0);
   endtask

   initial begin
      int n;
      #1 sys_rst_n = 1'b0;
      step(2);
      chk_zero("reset");
      sys_rst_n = 1'b1;
      step(1);

      // 1: single held note, shift 1
      shift = 2'd1;
      do_clear();
      recording = 1'b1;
      key = 8'h04;
      step(10);
      chk("t1_before_release", int'(output_ready), 0);
      key = 8'h00;
      step(1);
      chk("t1_ready", int'(output_ready), 1);
      chk("t1_data", int'(data_out), 10'h143);

      // 2: back-to-back notes, multi-key resolves low
      do_clear();
      key = 8'h01;
      step(2);
      key = 8'h02;
      step(1);
      chk("t2_first", int'(data_out), 10'h101);
      key = 8'h06;
      step(1);
      key = 8'h00;
      step(1);
      chk("t2_head", int'(data_out), 10'h101);
      pop1();
      chk("t2_second", int'(data_out), 10'h122);

      // 3: length and duration saturation
      shift = 2'd0;
      do_clear();
      key = 8'h08;
      step(4 * 34);
      key = 8'h00;
      step(1);
      chk("t3_len_sat", int'(data_out), 10'h07F);
      pop1();
      step(4 * 1030);
      chk("t3_dur_sat", int'(duration), 1023);

      // 4: overflow, then push+pop while full
      do_clear();
      for (int k = 0; k < 18; k++) begin
         key = (k % 2 != 0) ? 8'h02 : 8'h01;
         step(1);
      end
      chk("t4_ovf", int'(overflow), 1);
      chk("t4_ready", int'(output_ready), 1);
      chk("t4_head", int'(data_out), 10'h001);
      key = 8'h01;
      force_ack = 1'b1;
      step(1);
      force_ack = 1'b0;
      chk("t4_ovf_kept", int'(overflow), 1);
      chk("t4_head2", int'(data_out), 10'h021);
      n = 0;
      while (output_ready && n < 40) begin
         pop1();
         n++;
      end
      chk("t4_count", n, 16);

      // 5: recording falls mid-note; ack on empty
      do_clear();
      key = 8'h10;
      step(6);
      recording = 1'b0;
      step(1);
      chk("t5_ready", int'(output_ready), 1);
      chk("t5_data", int'(data_out), 10'h082);
      step(10);
      chk("t5_dur_frozen", int'(duration), 1);
      pop1();
      chk("t5_empty", int'(output_ready), 0);
      pop1();
      chk("t5_empty_ack_ready", int'(output_ready), 0);
      chk("t5_empty_ack_data", int'(data_out), 0);
      key = 8'h00;

      // 6: clear and async reset during HOLD with 3 queued
      recording = 1'b1;
      do_clear();
      for (int k = 0; k < 4; k++) begin
         key = (k % 2 != 0) ? 8'h02 : 8'h01;
         step(1);
      end
      step(6);
      chk("t6_ready", int'(output_ready), 1);
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      key = 8'h00;
      chk("t6_clr_ready", int'(output_ready), 0);
      chk("t6_clr_dur", int'(duration), 0);
      step(3);
      chk("t6_no_push", int'(output_ready), 0);
      for (int k = 0; k < 4; k++) begin
         key = (k % 2 != 0) ? 8'h02 : 8'h01;
         step(1);
      end
      step(6);
      chk("t6_pre_rst_ready", int'(output_ready), 1);
      #1 sys_rst_n = 1'b0;
      #1 chk_zero("t6_async_rst");
      step(2);
      sys_rst_n = 1'b1;
      key = 8'h00;
      step(1);

      // Random traffic against the model
      cons_en   = 1'b1;
      recording = 1'b1;
      for (int s = 0; s < 300; s++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r < 3)      key = 8'h00;
         else if (r < 7) key = 8'(1 << $urandom_range(0, 7));
         else            key = 8'($urandom_range(1, 255));
         if ($urandom_range(0, 3) == 0) shift = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) recording = ~recording;
         if ($urandom_range(0, 19) == 0)
            pop_pct = ($urandom_range(0, 3) == 0) ? 0 :
                      int'($urandom_range(20, 90));
         clear = ($urandom_range(0, 39) == 0);
         step(1);
         clear = 1'b0;
         step(int'($urandom_range(0, 10)));
      end
      key       = 8'h00;
      recording = 1'b0;
      pop_pct   = 100;
      step(40);
      chk("final_drained", int'(output_ready), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
